// File: rtl/spi_cmd_decoder.sv
// SPI command decoder: checksum check, field split and FWFT command FIFO.
// Ports: clk/rst_, i_Acc_* (frame in), o_Cmd_*/i_Cmd_Ready (out), error counters.
module spi_cmd_decoder #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     rst_,
   input  logic                     i_Acc_DV,
   input  logic [63:0]              i_Acc_Bytes,
   output logic                     o_Cmd_Valid,
   input  logic                     i_Cmd_Ready,
   output logic [7:0]               o_Cmd_Op,
   output logic [7:0]               o_Cmd_Addr,
   output logic [31:0]              o_Cmd_Data,
   output logic [$clog2(DEPTH):0]   o_Fifo_Count,
   output logic [CNT_W-1:0]         o_Err_Chk_Cnt,
   output logic [CNT_W-1:0]         o_Err_Ovf_Cnt,
   input  logic                     i_Err_Clr
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [CNT_W-1:0] SAT = '1;

   logic        r_s1_vld;
   logic        r_s1_good;
   logic [47:0] r_s1_word;

   logic [47:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;

   logic [CNT_W-1:0] r_chk_cnt;
   logic [CNT_W-1:0] r_ovf_cnt;

   logic [7:0]  w_xor;
   logic        w_empty;
   logic        w_full;
   logic        w_pop;
   logic        w_push;
   logic        w_ovf;
   logic        w_bad;
   logic [47:0] w_head;

   // XOR of the seven leading bytes (reserved byte included).
   assign w_xor = i_Acc_Bytes[63:56] ^ i_Acc_Bytes[55:48]
                ^ i_Acc_Bytes[47:40] ^ i_Acc_Bytes[39:32]
                ^ i_Acc_Bytes[31:24] ^ i_Acc_Bytes[23:16]
                ^ i_Acc_Bytes[15:8];

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == FULL_CNT);
   assign w_pop   = !w_empty && i_Cmd_Ready;
   // A pop in the same cycle frees the slot a full FIFO needs.
   assign w_push  = r_s1_vld && r_s1_good && (!w_full || w_pop);
   assign w_ovf   = r_s1_vld && r_s1_good && w_full && !w_pop;
   assign w_bad   = r_s1_vld && !r_s1_good;

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         r_s1_vld  <= 1'b0;
         r_s1_good <= 1'b0;
         r_s1_word <= '0;
      end else begin
         r_s1_vld <= i_Acc_DV;
         if (i_Acc_DV) begin
            r_s1_good <= (w_xor == i_Acc_Bytes[7:0]);
            r_s1_word <= i_Acc_Bytes[63:16];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_push) begin
         r_mem[r_wptr] <= r_s1_word;
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         r_chk_cnt <= '0;
         r_ovf_cnt <= '0;
      end else if (i_Err_Clr) begin
         r_chk_cnt <= '0;
         r_ovf_cnt <= '0;
      end else begin
         if (w_bad && (r_chk_cnt != SAT)) begin
            r_chk_cnt <= r_chk_cnt + CNT_W'(1);
         end
         if (w_ovf && (r_ovf_cnt != SAT)) begin
            r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
         end
      end
   end

   assign w_head        = r_mem[r_rptr];
   assign o_Cmd_Valid   = !w_empty;
   assign o_Cmd_Op      = w_head[47:40];
   assign o_Cmd_Addr    = w_head[39:32];
   assign o_Cmd_Data    = w_head[31:0];
   assign o_Fifo_Count  = r_count;
   assign o_Err_Chk_Cnt = r_chk_cnt;
   assign o_Err_Ovf_Cnt = r_ovf_cnt;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Testbench for spi_cmd_decoder: queue-based reference model and scoreboard.
// Directed scenarios plus randomized traffic; one summary line at the end.
module tb_spi_cmd_decoder;

   localparam int DEPTH = 4;
   localparam int CNT_W = 8;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic        clk;
   logic        rst_;
   logic        i_Acc_DV;
   logic [63:0] i_Acc_Bytes;
   logic        o_Cmd_Valid;
   logic        i_Cmd_Ready;
   logic [7:0]  o_Cmd_Op;
   logic [7:0]  o_Cmd_Addr;
   logic [31:0] o_Cmd_Data;
   logic [$clog2(DEPTH):0] o_Fifo_Count;
   logic [CNT_W-1:0] o_Err_Chk_Cnt;
   logic [CNT_W-1:0] o_Err_Ovf_Cnt;
   logic        i_Err_Clr;

   spi_cmd_decoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rst_          (rst_),
      .i_Acc_DV      (i_Acc_DV),
      .i_Acc_Bytes   (i_Acc_Bytes),
      .o_Cmd_Valid   (o_Cmd_Valid),
      .i_Cmd_Ready   (i_Cmd_Ready),
      .o_Cmd_Op      (o_Cmd_Op),
      .o_Cmd_Addr    (o_Cmd_Addr),
      .o_Cmd_Data    (o_Cmd_Data),
      .o_Fifo_Count  (o_Fifo_Count),
      .o_Err_Chk_Cnt (o_Err_Chk_Cnt),
      .o_Err_Ovf_Cnt (o_Err_Ovf_Cnt),
      .i_Err_Clr     (i_Err_Clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int n_pop = 0;
   bit mon_en = 1'b0;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Frame rule: chk byte equals XOR of the seven preceding bytes.
   function automatic logic [7:0] xor7(logic [63:0] f);
      logic [7:0] x;
      x = 8'h00;
      for (int b = 1; b < 8; b++) x ^= f[b*8 +: 8];
      return x;
   endfunction

   function automatic bit is_good(logic [63:0] f);
      return xor7(f) == f[7:0];
   endfunction

   function automatic logic [63:0] mk_frame(bit good);
      logic [63:0] f;
      logic [7:0]  e;
      f = {$urandom(), $urandom()};
      f[7:0] = xor7(f);
      if (!good) begin
         e = 8'($urandom_range(1, 255));
         f[7:0] ^= e;
      end
      return f;
   endfunction

   // Reference model: a queue of accepted frames and two integer counters.
   logic [63:0] m_s1;
   bit          m_s1v;
   logic [47:0] m_q[$];
   int          m_chk;
   int          m_ovf;

   always @(posedge clk or negedge rst_) begin
      bit pop;
      bit push;
      if (!rst_) begin
         m_q.delete();
         m_s1v = 1'b0;
         m_s1  = '0;
         m_chk = 0;
         m_ovf = 0;
      end else begin
         pop  = (m_q.size() > 0) && i_Cmd_Ready;
         push = 1'b0;
         if (m_s1v) begin
            if (!is_good(m_s1)) begin
               if (m_chk < CMAX) m_chk++;
            end else if (m_q.size() < DEPTH || pop) begin
               push = 1'b1;
            end else begin
               if (m_ovf < CMAX) m_ovf++;
            end
         end
         if (i_Err_Clr) begin
            m_chk = 0;
            m_ovf = 0;
         end
         if (pop) void'(m_q.pop_front());
         if (push) m_q.push_back(m_s1[63:16]);
         m_s1v = i_Acc_DV;
         m_s1  = i_Acc_Bytes;
      end
   end

   // Monitor: DUT outputs against the model between clock edges.
   always @(negedge clk) begin
      if (mon_en && rst_) begin
         check("valid", 64'(o_Cmd_Valid), 64'(m_q.size() > 0));
         check("count", 64'(o_Fifo_Count), 64'(m_q.size()));
         check("err_chk", 64'(o_Err_Chk_Cnt), 64'(m_chk));
         check("err_ovf", 64'(o_Err_Ovf_Cnt), 64'(m_ovf));
         if (o_Cmd_Valid && m_q.size() > 0) begin
            check("head", 64'({o_Cmd_Op, o_Cmd_Addr, o_Cmd_Data}), 64'(m_q[0]));
         end
         if (o_Cmd_Valid && i_Cmd_Ready) n_pop++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(logic [63:0] f);
      i_Acc_DV    = 1'b1;
      i_Acc_Bytes = f;
      tick();
      i_Acc_DV    = 1'b0;
   endtask

   int p0;

   initial begin
      rst_        = 1'b0;
      i_Acc_DV    = 1'b0;
      i_Acc_Bytes = '0;
      i_Cmd_Ready = 1'b0;
      i_Err_Clr   = 1'b0;
      tick();
      tick();
      check("rst_valid", 64'(o_Cmd_Valid), 64'd0);
      check("rst_count", 64'(o_Fifo_Count), 64'd0);
      check("rst_chk", 64'(o_Err_Chk_Cnt), 64'd0);
      check("rst_ovf", 64'(o_Err_Ovf_Cnt), 64'd0);
      check("rst_head_known", 64'($isunknown({o_Cmd_Op, o_Cmd_Addr, o_Cmd_Data})), 64'd0);
      rst_ = 1'b1;
      tick();
      mon_en = 1'b1;

      // Single good frame: two-cycle latency then one pop.
      send(64'h0110AABBCCDD0011);
      check("lat1_valid", 64'(o_Cmd_Valid), 64'd0);
      tick();
      check("lat2_valid", 64'(o_Cmd_Valid), 64'd1);
      check("one_op", 64'(o_Cmd_Op), 64'h01);
      check("one_addr", 64'(o_Cmd_Addr), 64'h10);
      check("one_data", 64'(o_Cmd_Data), 64'hAABBCCDD);
      check("one_count", 64'(o_Fifo_Count), 64'd1);
      i_Cmd_Ready = 1'b1;
      tick();
      i_Cmd_Ready = 1'b0;
      check("pop_count", 64'(o_Fifo_Count), 64'd0);
      check("pop_valid", 64'(o_Cmd_Valid), 64'd0);

      // Bad checksum.
      send(64'h0110AABBCCDD0012);
      tick();
      check("bad_chk", 64'(o_Err_Chk_Cnt), 64'd1);
      check("bad_valid", 64'(o_Cmd_Valid), 64'd0);
      check("bad_count", 64'(o_Fifo_Count), 64'd0);

      // Overflow: DEPTH+2 frames with no consumer.
      for (int i = 0; i < DEPTH + 2; i++) send(mk_frame(1'b1));
      tick();
      tick();
      check("ovf_count", 64'(o_Fifo_Count), 64'(DEPTH));
      check("ovf_cnt", 64'(o_Err_Ovf_Cnt), 64'd2);

      // Full FIFO: pop coincides with the new frame's write.
      send(mk_frame(1'b1));
      i_Cmd_Ready = 1'b1;
      tick();
      i_Cmd_Ready = 1'b0;
      check("fullpp_count", 64'(o_Fifo_Count), 64'(DEPTH));
      check("fullpp_ovf", 64'(o_Err_Ovf_Cnt), 64'd2);
      i_Cmd_Ready = 1'b1;
      for (int i = 0; i < DEPTH + 2; i++) tick();
      i_Cmd_Ready = 1'b0;
      check("drain_count", 64'(o_Fifo_Count), 64'd0);

      // Back-to-back frames with a consumer always ready.
      p0 = n_pop;
      i_Cmd_Ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         i_Acc_DV    = 1'b1;
         i_Acc_Bytes = mk_frame(1'b1);
         tick();
      end
      i_Acc_DV = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      i_Cmd_Ready = 1'b0;
      check("b2b_pops", 64'(n_pop - p0), 64'd20);
      check("b2b_count", 64'(o_Fifo_Count), 64'd0);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         i_Acc_DV    = 1'($urandom_range(0, 1));
         i_Acc_Bytes = mk_frame($urandom_range(0, 9) < 8);
         i_Cmd_Ready = 1'($urandom_range(0, 2) == 0);
         i_Err_Clr   = ($urandom_range(0, 19) == 0);
         tick();
      end
      i_Acc_DV  = 1'b0;
      i_Err_Clr = 1'b0;
      i_Cmd_Ready = 1'b1;
      for (int i = 0; i < DEPTH + 2; i++) tick();
      i_Cmd_Ready = 1'b0;

      // Checksum counter saturation and clear priority.
      i_Err_Clr = 1'b1;
      tick();
      i_Err_Clr = 1'b0;
      for (int i = 0; i < 300; i++) begin
         i_Acc_DV    = 1'b1;
         i_Acc_Bytes = mk_frame(1'b0);
         tick();
      end
      i_Acc_DV = 1'b0;
      tick();
      check("chk_sat", 64'(o_Err_Chk_Cnt), 64'(CMAX));
      i_Err_Clr = 1'b1;
      tick();
      i_Err_Clr = 1'b0;
      send(mk_frame(1'b0));
      tick();
      check("chk_one", 64'(o_Err_Chk_Cnt), 64'd1);
      send(mk_frame(1'b0));
      i_Err_Clr = 1'b1;
      tick();
      i_Err_Clr = 1'b0;
      check("clr_prio", 64'(o_Err_Chk_Cnt), 64'd0);

      // Reset mid-stream flushes stored and in-flight frames.
      for (int i = 0; i < 3; i++) send(mk_frame(1'b1));
      i_Acc_DV    = 1'b1;
      i_Acc_Bytes = mk_frame(1'b1);
      #2;
      rst_ = 1'b0;
      #1;
      check("mrst_valid", 64'(o_Cmd_Valid), 64'd0);
      check("mrst_count", 64'(o_Fifo_Count), 64'd0);
      i_Acc_DV = 1'b0;
      tick();
      tick();
      rst_ = 1'b1;
      tick();
      tick();
      check("post_rst_valid", 64'(o_Cmd_Valid), 64'd0);
      send(mk_frame(1'b1));
      tick();
      check("post_rst_count", 64'(o_Fifo_Count), 64'd1);
      i_Cmd_Ready = 1'b1;
      tick();
      i_Cmd_Ready = 1'b0;
      tick();
      check("end_count", 64'(o_Fifo_Count), 64'd0);

      mon_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
